// File: rtl/vga_timing_pkg.sv
// Mode and polarity constants shared by the VGA timing generator and its users.
// Includes the standard 640x480 mode and a tiny mode for quick simulation.
package vga_timing_pkg;

    localparam int POL_NEG = 0;
    localparam int POL_POS = 1;

    localparam int VGA_H_DISPW = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_PW    = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_V_DISPW = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_PW    = 2;
    localparam int VGA_V_BP    = 33;

    localparam int SIM_H_DISPW = 8;
    localparam int SIM_H_FP    = 2;
    localparam int SIM_H_PW    = 6;
    localparam int SIM_H_BP    = 4;
    localparam int SIM_V_DISPW = 6;
    localparam int SIM_V_FP    = 4;
    localparam int SIM_V_PW    = 2;
    localparam int SIM_V_BP    = 3;

    // Bit positions of the signals carried through the sync delay line.
    localparam int SYNC_W     = 4;
    localparam int SYNC_HS    = 0;
    localparam int SYNC_VS    = 1;
    localparam int SYNC_BLANK = 2;
    localparam int SYNC_DE    = 3;

    function automatic int vga_total(input int dispw, input int fp, input int pw, input int bp);
        return dispw + fp + pw + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// CE-gated shift register of configurable depth with per-bit clear values.
// A depth of zero collapses to a plain wire.
module vga_sync_delay #(
    parameter int             DEPTH   = 0,
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst_n, i_ce};
            assign o_q      = i_d;
        end else begin : g_pipe
            logic [W-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
                end else if (i_ce) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, sync, blank/DE, coordinates and strobes.
// Outputs are registered from the next-state counters so they line up with HCNT_O/VCNT_O.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPW = VGA_H_DISPW,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_PW    = VGA_H_PW,
    parameter int H_BP    = VGA_H_BP,
    parameter int H_POL   = POL_NEG,
    parameter int V_DISPW = VGA_V_DISPW,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_PW    = VGA_V_PW,
    parameter int V_BP    = VGA_V_BP,
    parameter int V_POL   = POL_NEG,
    parameter int CNT_W   = 11,
    parameter int DELAY   = 0
) (
    input  logic             PCLK_I,
    input  logic             RST_I,
    input  logic             CE_I,
    output logic [CNT_W-1:0] HCNT_O,
    output logic [CNT_W-1:0] VCNT_O,
    output logic [CNT_W-1:0] X_O,
    output logic [CNT_W-1:0] Y_O,
    output logic             HSYNC_O,
    output logic             VSYNC_O,
    output logic             BLANK_O,
    output logic             DE_O,
    output logic             LINE_O,
    output logic             FRAME_O
);

    localparam int HTOT = vga_total(H_DISPW, H_FP, H_PW, H_BP);
    localparam int VTOT = vga_total(V_DISPW, V_FP, V_PW, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HTOT - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_DISPW);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_DISPW + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_DISPW + H_FP + H_PW);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VTOT - 1);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_DISPW);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_DISPW + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_DISPW + V_FP + V_PW);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    generate
        if (HTOT > (1 << CNT_W) || VTOT > (1 << CNT_W)) begin : g_bad_width
            $error("vga_timing_gen: HTOT/VTOT do not fit in CNT_W bits");
        end
        if (H_DISPW < 1 || H_FP < 1 || H_PW < 1 || H_BP < 1 ||
            V_DISPW < 1 || V_FP < 1 || V_PW < 1 || V_BP < 1) begin : g_bad_mode
            $error("vga_timing_gen: widths and porches must be at least 1");
        end
        if (DELAY < 0 || DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: DELAY must be in 0..7");
        end
    endgenerate

    logic [CNT_W-1:0] r_hcnt, r_vcnt, r_x, r_y;
    logic             r_hsync, r_vsync, r_blank, r_line, r_frame;

    logic [CNT_W-1:0] w_hnext, w_vnext;
    logic             w_hwrap, w_active, w_hs_win, w_vs_win;
    logic [SYNC_W-1:0] w_sync_d, w_sync_q;

    always_comb begin
        w_hwrap  = (r_hcnt == H_LAST);
        w_hnext  = w_hwrap ? '0 : r_hcnt + CNT_W'(1);
        w_vnext  = r_vcnt;
        if (w_hwrap) begin
            w_vnext = (r_vcnt == V_LAST) ? '0 : r_vcnt + CNT_W'(1);
        end
        w_active = (w_hnext < H_ACT) && (w_vnext < V_ACT);
        w_hs_win = (w_hnext >= H_SS) && (w_hnext < H_SE);
        w_vs_win = (w_vnext >= V_SS) && (w_vnext < V_SE);
    end

    always_ff @(posedge PCLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_hcnt  <= H_LAST;
            r_vcnt  <= V_LAST;
            r_x     <= '0;
            r_y     <= '0;
            r_hsync <= ~HS_ON;
            r_vsync <= ~VS_ON;
            r_blank <= 1'b1;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else if (CE_I) begin
            r_hcnt  <= w_hnext;
            r_vcnt  <= w_vnext;
            r_x     <= w_active ? w_hnext : '0;
            r_y     <= w_active ? w_vnext : '0;
            r_hsync <= w_hs_win ? HS_ON : ~HS_ON;
            r_vsync <= w_vs_win ? VS_ON : ~VS_ON;
            r_blank <= ~w_active;
            r_line  <= (w_hnext == '0);
            r_frame <= (w_hnext == '0) && (w_vnext == '0);
        end
    end

    // Only the video-facing signals are delayed; counters and strobes stay on time.
    always_comb begin
        w_sync_d             = '0;
        w_sync_d[SYNC_HS]    = r_hsync;
        w_sync_d[SYNC_VS]    = r_vsync;
        w_sync_d[SYNC_BLANK] = r_blank;
        w_sync_d[SYNC_DE]    = ~r_blank;
    end

    vga_sync_delay #(
        .DEPTH   (DELAY),
        .W       (SYNC_W),
        .RST_VAL ({1'b0, 1'b1, ~VS_ON, ~HS_ON})
    ) u_sync_delay (
        .i_clk   (PCLK_I),
        .i_rst_n (RST_I),
        .i_ce    (CE_I),
        .i_d     (w_sync_d),
        .o_q     (w_sync_q)
    );

    assign HCNT_O  = r_hcnt;
    assign VCNT_O  = r_vcnt;
    assign X_O     = r_x;
    assign Y_O     = r_y;
    assign HSYNC_O = w_sync_q[SYNC_HS];
    assign VSYNC_O = w_sync_q[SYNC_VS];
    assign BLANK_O = w_sync_q[SYNC_BLANK];
    assign DE_O    = w_sync_q[SYNC_DE];
    assign LINE_O  = r_line;
    assign FRAME_O = r_frame;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator; successor to the fixed-constant VGA timing block. Produces horizontal/vertical counters, sync, blank/data-enable, active-pixel coordinates and frame/line strobes for any video mode. Adds a clock enable, a programmable sync-polarity per axis, and a DELAY pipeline that aligns sync/blank with a downstream pixel pipeline. Sits between the pixel-clock source and the tile/colour renderer feeding the VGA DAC.

Parameters:
H_DISPW, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_PW, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
H_POL, 0, hsync polarity (0 = active-low, 1 = active-high)
V_DISPW, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_PW, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
V_POL, 0, vsync polarity (0 = active-low, 1 = active-high)
CNT_W, 11, counter/coordinate width; must satisfy 2^CNT_W >= max(HTOT, VTOT)
DELAY, 0, extra register stages on HSYNC_O/VSYNC_O/BLANK_O/DE_O (0..7)

Ports:
PCLK_I  in  1  pixel clock
RST_I  in  1  asynchronous, active-low reset
CE_I  in  1  clock enable; all state advances only when high
HCNT_O  out  CNT_W  horizontal counter, 0..HTOT-1
VCNT_O  out  CNT_W  vertical counter, 0..VTOT-1
X_O  out  CNT_W  active pixel x (equals HCNT_O when active, else 0)
Y_O  out  CNT_W  active pixel y (equals VCNT_O when active, else 0)
HSYNC_O  out  1  horizontal sync at the configured polarity, delayed by DELAY
VSYNC_O  out  1  vertical sync at the configured polarity, delayed by DELAY
BLANK_O  out  1  high outside active video, delayed by DELAY
DE_O  out  1  equals ~BLANK_O
LINE_O  out  1  one-cycle strobe when HCNT_O==0 (undelayed)
FRAME_O  out  1  one-cycle strobe when HCNT_O==0 and VCNT_O==0 (undelayed)

Behaviour:
- Definitions: HTOT = H_DISPW+H_FP+H_PW+H_BP; VTOT = V_DISPW+V_FP+V_PW+V_BP.
- Line order: active [0, H_DISPW), front porch, sync [H_DISPW+H_FP, H_DISPW+H_FP+H_PW), back porch. The vertical axis uses the same order in lines.
- Reset (RST_I low, asynchronous):
  - HCNT = HTOT-1, VCNT = VTOT-1; X = Y = 0.
  - BLANK_O = 1, DE_O = 0, LINE_O = FRAME_O = 0.
  - Syncs at their inactive level (~H_POL, ~V_POL).
  - All DELAY stages are cleared to the same blank/inactive values.
  - The first enabled edge after release yields HCNT = VCNT = 0.
- Counting, on each PCLK_I edge with CE_I high:
  - HCNT wraps from HTOT-1 to 0, otherwise increments.
  - VCNT changes only when HCNT wraps: VTOT-1 goes to 0, otherwise it increments.
- Decode: all outputs are registered and decoded from the next-state counter values, so they are cycle-aligned with HCNT_O/VCNT_O when DELAY = 0.
  - active = (HCNT < H_DISPW) && (VCNT < V_DISPW)
  - hsync asserted while HCNT is in the sync window, on every line including vertical blanking
  - vsync asserted while VCNT is in the sync window, for whole lines from HCNT = 0
- Delay: HSYNC/VSYNC/BLANK/DE pass through a DELAY-stage shift register that advances only with CE_I. Counters, X/Y and the strobes are never delayed.
- CE_I low: every register holds, including the delay line. Strobes hold their value, so downstream qualifies them with CE_I.
- RST_I asserted mid-frame: immediate return to the reset state, with no partial sync pulse afterwards.
- Arithmetic: all comparisons are unsigned at CNT_W. Parameter sums are computed as localparams at 32 bits.
- Elaboration-time checks fail when:
  - HTOT or VTOT exceeds 2^CNT_W;
  - any width or porch parameter is less than 1;
  - DELAY is greater than 7.

Decomposition:
- vga_timing_pkg holds the mode constants (VGA_640x480 defaults, the small simulation mode 8/2/6/4 and 6/4/2/3) and the polarity constants POL_NEG/POL_POS.
- One sub-module, vga_sync_delay: a parametrised-depth, CE-gated shift register with async active-low clear and per-bit reset values, covering 4 bits. At depth 0 it is a wire.

Test Plan:
All scenarios use the small mode (H 8/2/6/4, V 6/4/2/3, HTOT = 20, VTOT = 15) unless stated.
- Reset release, CE_I = 1, DELAY = 0:
  - first edge gives HCNT = 0, VCNT = 0, BLANK_O = 0, LINE_O = 1, FRAME_O = 1;
  - HCNT = 8 gives BLANK_O = 1;
  - HSYNC_O is low exactly for HCNT 10..15.
- Full frame:
  - VSYNC_O is low exactly for VCNT 10..11 (40 clocks);
  - FRAME_O pulses once every 300 enabled clocks;
  - HCNT = 19, VCNT = 14 is followed by 0, 0.
- CE_I toggling 1,0,0,1 mid-line: HCNT, sync and blank hold for 2 cycles, then resume with no skipped count.
- DELAY = 2: HSYNC_O/BLANK_O transitions lag the DELAY = 0 instance by exactly 2 enabled clocks, while HCNT_O is identical.
- H_POL = 1, V_POL = 1: sync pulses are inverted (high during windows 10..15 and 10..11); reset level is 0.
- RST_I asserted at HCNT = 12 (inside hsync): outputs go to reset values asynchronously within the same cycle; after release, counting restarts at 0, 0.
